// File: rtl/coffee_pkg.sv
// Shared encodings for the coffee order sequencer: FSM states, stock indices
// and the failure codes reported to the front panel.
package coffee_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      S_BTN      = 3'd1,
      S_WATER    = 3'd2,
      S_MILK     = 3'd3,
      S_COFFEE   = 3'd4,
      S_SUGAR    = 3'd5,
      WAIT_READY = 3'd6
   } state_t;

   localparam int NUM_STOCK = 5;
   localparam int WATER     = 0;
   localparam int MILK      = 1;
   localparam int COFFEE    = 2;
   localparam int SUGAR     = 3;
   localparam int CUP       = 4;

   typedef enum logic [2:0] {
      FAIL_NONE    = 3'd0,
      FAIL_WATER   = 3'd1,
      FAIL_MILK    = 3'd2,
      FAIL_COFFEE  = 3'd3,
      FAIL_SUGAR   = 3'd4,
      FAIL_CUP     = 3'd5,
      FAIL_TIMEOUT = 3'd6
   } fail_t;

endpackage

// File: rtl/stock_counter.sv
// One ingredient stock counter: saturating refill, decrement on commit and
// a combinational low-stock flag.
module stock_counter #(
   parameter int CNT_W      = 4,
   parameter int INIT_STOCK = 8,
   parameter int LOW_THRESH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_refill,
   input  logic [CNT_W-1:0] i_amt,
   input  logic             i_commit,
   output logic [CNT_W-1:0] o_stock,
   output logic             o_low
);

   logic [CNT_W-1:0] r_stock;
   logic [CNT_W-1:0] w_sat;
   logic [CNT_W-1:0] w_next;

   // Sum never exceeds 2*(2**CNT_W-1), so a carry out means overflow.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
      logic [CNT_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[CNT_W] ? '1 : s[CNT_W-1:0];
   endfunction

   always_comb begin
      w_sat  = i_refill ? sat_add(r_stock, i_amt) : r_stock;
      w_next = w_sat;
      if (i_commit && (w_sat != '0))
         w_next = w_sat - 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_stock <= CNT_W'(INIT_STOCK);
      else
         r_stock <= w_next;
   end

   assign o_stock = r_stock;
   assign o_low   = (r_stock <= CNT_W'(LOW_THRESH));

endmodule

// File: rtl/coffee_order_sequencer.sv
// Transmit side of the coffee-machine step protocol: serialises one order as
// button + four availability bits, waits for coffee_ready and commits stock.
module coffee_order_sequencer
   import coffee_pkg::*;
#(
   parameter int CNT_W       = 4,
   parameter int INIT_STOCK  = 8,
   parameter int LOW_THRESH  = 1,
   parameter int ACK_TIMEOUT = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_order_req,
   input  logic             i_refill_valid,
   input  logic [2:0]       i_refill_sel,
   input  logic [CNT_W-1:0] i_refill_amt,
   input  logic             i_coffee_ready,
   output logic             o_ser_out,
   output logic             o_order_busy,
   output logic             o_order_done,
   output logic             o_order_fail,
   output logic [2:0]       o_fail_code,
   output logic [4:0]       o_stock_low,
   output logic [7:0]       o_served_cnt
);

   localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

   state_t                           r_state, w_next_state;
   logic                             r_ser_out, w_ser_next;
   logic                             r_done, w_done_next;
   logic                             r_fail, w_fail_next;
   fail_t                            r_fail_code, w_code_next;
   logic [TMO_W-1:0]                 r_tmo, w_tmo_next;
   logic [7:0]                       r_served;
   logic                             w_commit;
   logic [NUM_STOCK-1:0][CNT_W-1:0]  w_stock;
   logic [NUM_STOCK-1:0]             w_low;

   genvar g;
   generate
      for (g = 0; g < NUM_STOCK; g++) begin : g_stock
         stock_counter #(
            .CNT_W      (CNT_W),
            .INIT_STOCK (INIT_STOCK),
            .LOW_THRESH (LOW_THRESH)
         ) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .i_refill (i_refill_valid && (i_refill_sel == 3'(g))),
            .i_amt    (i_refill_amt),
            .i_commit (w_commit),
            .o_stock  (w_stock[g]),
            .o_low    (w_low[g])
         );
      end
   endgenerate

   // ser_out is loaded with the bit of the state being entered, so each
   // availability bit reflects stock at the edge that starts its cycle.
   always_comb begin
      w_next_state = r_state;
      w_ser_next   = 1'b0;
      w_done_next  = 1'b0;
      w_fail_next  = 1'b0;
      w_code_next  = r_fail_code;
      w_tmo_next   = r_tmo;
      w_commit     = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_order_req) begin
               if (w_stock[CUP] == '0) begin
                  w_fail_next = 1'b1;
                  w_code_next = FAIL_CUP;
               end else begin
                  w_next_state = S_BTN;
                  w_ser_next   = 1'b1;
                  w_code_next  = FAIL_NONE;
               end
            end
         end
         S_BTN: begin
            w_next_state = S_WATER;
            w_ser_next   = (w_stock[WATER] != '0);
         end
         S_WATER: begin
            if (!r_ser_out) begin
               w_next_state = IDLE;
               w_fail_next  = 1'b1;
               w_code_next  = FAIL_WATER;
            end else begin
               w_next_state = S_MILK;
               w_ser_next   = (w_stock[MILK] != '0);
            end
         end
         S_MILK: begin
            if (!r_ser_out) begin
               w_next_state = IDLE;
               w_fail_next  = 1'b1;
               w_code_next  = FAIL_MILK;
            end else begin
               w_next_state = S_COFFEE;
               w_ser_next   = (w_stock[COFFEE] != '0);
            end
         end
         S_COFFEE: begin
            if (!r_ser_out) begin
               w_next_state = IDLE;
               w_fail_next  = 1'b1;
               w_code_next  = FAIL_COFFEE;
            end else begin
               w_next_state = S_SUGAR;
               w_ser_next   = (w_stock[SUGAR] != '0);
            end
         end
         S_SUGAR: begin
            if (!r_ser_out) begin
               w_next_state = IDLE;
               w_fail_next  = 1'b1;
               w_code_next  = FAIL_SUGAR;
            end else begin
               w_next_state = WAIT_READY;
               w_tmo_next   = '0;
            end
         end
         WAIT_READY: begin
            if (i_coffee_ready) begin
               w_next_state = IDLE;
               w_done_next  = 1'b1;
               w_commit     = 1'b1;
            end else if (r_tmo == TMO_W'(ACK_TIMEOUT - 1)) begin
               w_next_state = IDLE;
               w_fail_next  = 1'b1;
               w_code_next  = FAIL_TIMEOUT;
            end else begin
               w_tmo_next = r_tmo + 1'b1;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_ser_out   <= 1'b0;
         r_done      <= 1'b0;
         r_fail      <= 1'b0;
         r_fail_code <= FAIL_NONE;
         r_tmo       <= '0;
         r_served    <= '0;
      end else begin
         r_state     <= w_next_state;
         r_ser_out   <= w_ser_next;
         r_done      <= w_done_next;
         r_fail      <= w_fail_next;
         r_fail_code <= w_code_next;
         r_tmo       <= w_tmo_next;
         if (w_commit)
            r_served <= r_served + 8'd1;
      end
   end

   assign o_ser_out    = r_ser_out;
   assign o_order_busy = (r_state != IDLE);
   assign o_order_done = r_done;
   assign o_order_fail = r_fail;
   assign o_fail_code  = r_fail_code;
   assign o_stock_low  = w_low;
   assign o_served_cnt = r_served;

endmodule
